// File: rtl/uart_xmt_if.sv
// Transmit-side handshake and line signals for uart_xmt.
// master drives the byte offer; slave is the transmitter.
interface uart_xmt_if #(
  parameter int wordsize = 8
);
  logic [wordsize-1:0] data_in;
  logic                data_valid;
  logic                data_ready;
  logic                serial_out;
  logic                busy;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  serial_out,
    input  busy
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output serial_out,
    output busy
  );
endinterface

// File: rtl/uart_xmt.sv
// Serial UART transmitter: one-byte holding register feeding a shift register, LSB first,
// each bit held samples_per_bit cycles. Define UART_XMT_PARITY_EN to add an even-parity bit.
module uart_xmt #(
  parameter int wordsize        = 8,
  parameter int samples_per_bit = 8
) (
  input  logic      sclk,
  input  logic      reset,
  uart_xmt_if.slave bus
);

  localparam int             SCW     = (samples_per_bit > 1) ? $clog2(samples_per_bit) : 1;
  localparam logic [SCW-1:0] SC_LAST = SCW'(samples_per_bit - 1);
  localparam logic [3:0]     BC_LAST = 4'(wordsize - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_XMT_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [wordsize-1:0] r_hold_reg;
  logic                r_hold_full;
  logic                w_hold_full_next;
  logic [wordsize-1:0] r_xmt_shftreg;
  logic [wordsize-1:0] w_shftreg_next;
  logic [wordsize-1:0] w_shifted;
  logic [SCW-1:0]      r_sample_counter;
  logic [SCW-1:0]      w_sample_counter_next;
  logic [3:0]          r_bit_counter;
  logic [3:0]          w_bit_counter_next;
  logic                r_serial_out;
  logic                w_serial_out_next;
  logic                w_boundary;
  logic                w_accept;
  logic                w_load;
`ifdef UART_XMT_PARITY_EN
  logic                r_parity;
`endif

  assign w_boundary = (r_sample_counter == SC_LAST);
  assign w_accept   = bus.data_valid && !r_hold_full;
  assign w_shifted  = r_xmt_shftreg >> 1;

  assign bus.data_ready = ~r_hold_full;
  assign bus.serial_out = r_serial_out;
  assign bus.busy       = (r_state != S_IDLE);

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next          = r_state;
    w_shftreg_next        = r_xmt_shftreg;
    w_hold_full_next      = r_hold_full;
    w_sample_counter_next = w_boundary ? '0 : r_sample_counter + 1'b1;
    w_bit_counter_next    = r_bit_counter;
    w_serial_out_next     = r_serial_out;
    w_load                = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_serial_out_next     = 1'b1;
        w_sample_counter_next = '0;
        if (r_hold_full) begin
          w_load             = 1'b1;
          w_state_next       = S_START;
          w_bit_counter_next = '0;
          w_serial_out_next  = 1'b0;
        end
      end
      S_START: begin
        if (w_boundary) begin
          w_state_next      = S_DATA;
          w_serial_out_next = r_xmt_shftreg[0];
        end
      end
      S_DATA: begin
        if (w_boundary) begin
          w_shftreg_next     = w_shifted;
          w_bit_counter_next = r_bit_counter + 4'd1;
          if (r_bit_counter == BC_LAST) begin
`ifdef UART_XMT_PARITY_EN
            w_state_next      = S_PARITY;
            w_serial_out_next = r_parity;
`else
            w_state_next      = S_STOP;
            w_serial_out_next = 1'b1;
`endif
          end else begin
            w_serial_out_next = w_shifted[0];
          end
        end
      end
`ifdef UART_XMT_PARITY_EN
      S_PARITY: begin
        if (w_boundary) begin
          w_state_next      = S_STOP;
          w_serial_out_next = 1'b1;
        end
      end
`endif
      S_STOP: begin
        w_serial_out_next = 1'b1;
        if (w_boundary) begin
          // a waiting byte starts immediately so consecutive frames have no idle gap
          if (r_hold_full) begin
            w_load             = 1'b1;
            w_state_next       = S_START;
            w_bit_counter_next = '0;
            w_serial_out_next  = 1'b0;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next          = S_IDLE;
        w_serial_out_next     = 1'b1;
        w_sample_counter_next = '0;
        w_bit_counter_next    = '0;
      end
    endcase

    if (w_load) begin
      w_shftreg_next   = r_hold_reg;
      w_hold_full_next = 1'b0;
    end
    // accept and load are exclusive: load needs a full holding register, accept an empty one
    if (w_accept) begin
      w_hold_full_next = 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      r_hold_reg       <= '0;
      r_hold_full      <= 1'b0;
      r_xmt_shftreg    <= '0;
      r_sample_counter <= '0;
      r_bit_counter    <= '0;
      r_serial_out     <= 1'b1;
    end else begin
      if (w_accept) begin
        r_hold_reg <= bus.data_in;
      end
      r_hold_full      <= w_hold_full_next;
      r_xmt_shftreg    <= w_shftreg_next;
      r_sample_counter <= w_sample_counter_next;
      r_bit_counter    <= w_bit_counter_next;
      r_serial_out     <= w_serial_out_next;
    end
  end

`ifdef UART_XMT_PARITY_EN
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= ^r_hold_reg;
    end
  end
`endif

endmodule
